fm_operator_nco: RTL

FM operator numerically-controlled oscillator: consumes the modulated tuning word produced by the phase-modulation stage, accumulates phase once per sample tick, and converts phase to a signed sine sample through a pipelined quarter-wave lookup. It sits between the modulation stage and the voice mixer, one instance per operator. Its output feeds back as the `mod_signal` of the next operator in the chain.

---
 rtl/synth_pkg.sv | 26 ++
 rtl/sine_quarter_rom.sv | 42 ++++
 rtl/fm_operator_nco.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// +----------------------------------------------------------------------------+
// | synth_pkg: constants shared by the FM synthesis voice blocks.               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package synth_pkg;

  localparam int         STATE_W   = 2;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam int PIPE_LATENCY = 3;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sine_quarter_rom.sv
// +----------------------------------------------------------------------------+
// | sine_quarter_rom: registered quarter-wave sine table, unsigned WF-bit data. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module sine_quarter_rom #(
  parameter int LUT_BITS = 10,
  parameter int WF       = 16
) (
  input  logic                clk,
  input  logic [LUT_BITS-1:0] addr_i,
  output logic [WF-1:0]       data_o
);

  localparam int DEPTH = 2 ** LUT_BITS;

  // Spans exactly 0..pi/2 so that entry 0 is 0 and the last entry is full scale
  function automatic logic [WF-1:0] lut_entry(input int k);
    real amp;
    real ang;
    amp = real'((2 ** WF) - 1);
    ang = (3.14159265358979323846 / 2.0) * real'(k) / real'(DEPTH - 1);
    return WF'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [WF-1:0] rom_table [DEPTH];
  logic [WF-1:0] data_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom_table[gi] = lut_entry(gi);
  end

  always_ff @(posedge clk) begin
    data_q <= rom_table[addr_i];
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/fm_operator_nco.sv
// +----------------------------------------------------------------------------+
// | fm_operator_nco: phase accumulator with 3-stage quarter-wave sine output.   |
// | Optional build macro: PHASE_DITHER_EN (LFSR dither on the ROM address).     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module fm_operator_nco
  import synth_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter int WI       = 2,
  parameter int WF       = 16,
  parameter int LUT_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                acc_en,
  input  logic                note_on,
  input  logic                note_off,
  input  logic [NUM_BITS-1:0] tuning_word,
  output logic [WI+WF-1:0]    sample,
  output logic                sample_valid,
  output logic                active,
  output logic [NUM_BITS-1:0] phase
);

  localparam int SW       = WI + WF;
  localparam int ADDR_MSB = NUM_BITS - 3;

  logic [STATE_W-1:0]  state_q, state_d;
  logic [NUM_BITS-1:0] phase_q, phase_d;
  logic [NUM_BITS:0]   sum;
  logic [NUM_BITS-1:0] addr_phase;
  logic                force_zero;

  assign sum = {1'b0, phase_q} + {1'b0, tuning_word};

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (note_on) begin
      state_d = S_RUN;
      phase_d = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (acc_en) phase_d = sum[NUM_BITS-1:0];
          if (note_off) state_d = S_RELEASE;
        end
        S_RELEASE: begin
          if (acc_en) begin
            if (sum[NUM_BITS]) begin
              state_d = S_IDLE;
              phase_d = '0;
            end else begin
              phase_d = sum[NUM_BITS-1:0];
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

`ifdef PHASE_DITHER_EN
  localparam int DITHER_SH = NUM_BITS - 2 - LUT_BITS - 16;

  if (DITHER_SH < 0) begin : g_dither_check
    $error("fm_operator_nco: PHASE_DITHER_EN needs NUM_BITS-2-LUT_BITS >= 16");
  end

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (acc_en) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  // Dither only perturbs the lookup address; the accumulator stays exact
  assign addr_phase = phase_q + (NUM_BITS'(lfsr_q) << DITHER_SH);
`else
  assign addr_phase = phase_q;
`endif

  assign force_zero = (state_q == S_IDLE) || note_on;

  // T0: capture
  logic                s0_valid_q;
  logic                s0_zero_q;
  logic [1:0]          s0_quad_q;
  logic [LUT_BITS-1:0] s0_addr_q;
  logic [LUT_BITS-1:0] rom_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_zero_q  <= 1'b0;
      s0_quad_q  <= '0;
      s0_addr_q  <= '0;
    end else begin
      s0_valid_q <= acc_en;
      if (acc_en) begin
        s0_zero_q <= force_zero;
        s0_quad_q <= addr_phase[NUM_BITS-1:NUM_BITS-2];
        s0_addr_q <= addr_phase[ADDR_MSB -: LUT_BITS];
      end
    end
  end

  assign rom_addr = s0_quad_q[0] ? ~s0_addr_q : s0_addr_q;

  // T1: ROM read, sideband delayed alongside
  logic          s1_valid_q;
  logic          s1_zero_q;
  logic          s1_neg_q;
  logic [WF-1:0] rom_data;

  sine_quarter_rom #(
    .LUT_BITS(LUT_BITS),
    .WF      (WF)
  ) u_rom (
    .clk   (clk),
    .addr_i(rom_addr),
    .data_o(rom_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_neg_q   <= 1'b0;
    end else begin
      s1_valid_q <= s0_valid_q;
      s1_zero_q  <= s0_zero_q;
      s1_neg_q   <= s0_quad_q[1];
    end
  end

  // T2: sign apply
  logic [SW-1:0] mag;
  logic [SW-1:0] sample_q, sample_d;
  logic          sample_valid_q;

  assign mag = {{WI{1'b0}}, rom_data};

  always_comb begin
    sample_d = sample_q;
    if (s1_valid_q) begin
      if (s1_zero_q)     sample_d = '0;
      else if (s1_neg_q) sample_d = -mag;
      else               sample_d = mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_q       <= sample_d;
      sample_valid_q <= s1_valid_q;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign active       = (state_q != S_IDLE);
  assign phase        = phase_q;

endmodule

`default_nettype wire
